// File: rtl/axi_stream_insert_header_if.sv
// Bus bundle for the header inserter: data-in, header side channel and output stream.
// slave is the inserter's view, master is the view of whatever drives and sinks it.
interface axi_stream_insert_header_if #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = 4,
    parameter int unsigned BYTE_CNT_WD  = 3
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    ready_insert;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_out,
        output ready_in, ready_insert,
        output valid_out, data_out, keep_out, last_out
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_out,
        input  ready_in, ready_insert,
        input  valid_out, data_out, keep_out, last_out
    );
endinterface

// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter: prepends 0..4 header bytes to each packet and
// re-packs the combined stream into full beats with a recomputed final keep.
module axi_stream_insert_header #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = 4,
    parameter int unsigned BYTE_CNT_WD  = 3
) (
    input  logic clk,
    input  logic rst_n,
    axi_stream_insert_header_if.slave bus
);
    localparam int unsigned CW = BYTE_CNT_WD + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [DATA_BYTE_WD-1:0] fkeep_q, fkeep_d;
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    ready_in_c, ready_insert_c;
    logic                    slot_free_c;
    logic [CW-1:0]           tot_c;

    function automatic logic [CW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) c = c + CW'(k[i]);
        return c;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] lmask(input logic [CW-1:0] n);
        logic [DATA_BYTE_WD-1:0] m;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++)
            m[int'(DATA_BYTE_WD) - 1 - i] = (CW'(i) < n);
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] bmask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int b = 0; b < int'(DATA_BYTE_WD); b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    // Low n bytes of hi followed by the top bytes of lo, i.e. {hi,lo} shifted right n bytes.
    function automatic logic [DATA_WD-1:0] pack(input logic [DATA_WD-1:0] hi,
                                                input logic [DATA_WD-1:0] lo,
                                                input logic [BYTE_CNT_WD-1:0] n);
        logic [2*DATA_WD-1:0] cat;
        cat = {hi, lo};
        cat = cat >> (32'(n) * 32'd8);
        return cat[DATA_WD-1:0];
    endfunction

    assign slot_free_c = !valid_q || bus.ready_out;
    assign tot_c       = CW'(cnt_q) + popcnt(bus.keep_in);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        res_d          = res_q;
        fkeep_d        = fkeep_q;
        valid_d        = valid_q;
        data_d         = data_q;
        keep_d         = keep_q;
        last_d         = last_q;
        ready_in_c     = 1'b0;
        ready_insert_c = 1'b0;

        if (slot_free_c) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_insert_c = slot_free_c;
                if (bus.valid_insert && slot_free_c) begin
                    cnt_d   = (bus.byte_insert_cnt > BYTE_CNT_WD'(DATA_BYTE_WD))
                              ? BYTE_CNT_WD'(DATA_BYTE_WD) : bus.byte_insert_cnt;
                    res_d   = bus.data_insert & bmask(bus.keep_insert);
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                ready_in_c = slot_free_c;
                if (bus.valid_in && slot_free_c) begin
                    valid_d = 1'b1;
                    res_d   = bus.data_in;
                    keep_d  = '1;
                    last_d  = 1'b0;
                    if (bus.last_in && tot_c <= CW'(DATA_BYTE_WD)) begin
                        keep_d  = lmask(tot_c);
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (bus.last_in) begin
                        fkeep_d = lmask(tot_c - CW'(DATA_BYTE_WD));
                        state_d = S_FLUSH;
                    end
                    data_d = pack(res_q, bus.data_in, cnt_q) & bmask(keep_d);
                end
            end
            S_FLUSH: begin
                if (slot_free_c) begin
                    valid_d = 1'b1;
                    keep_d  = fkeep_q;
                    last_d  = 1'b1;
                    data_d  = pack(res_q, '0, cnt_q) & bmask(fkeep_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!rst_n) begin
            ready_in_c     = 1'b0;
            ready_insert_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            fkeep_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            fkeep_q <= fkeep_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign bus.ready_in     = ready_in_c;
    assign bus.ready_insert = ready_insert_c;
    assign bus.valid_out    = valid_q;
    assign bus.data_out     = data_q;
    assign bus.keep_out     = keep_q;
    assign bus.last_out     = last_q;
endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for the header inserter: flush/no-flush packing, backpressure,
// pass-through, ordering and mid-packet reset.
module tb_axi_stream_insert_header;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    axi_stream_insert_header_if #(.DATA_WD(32), .DATA_BYTE_WD(4), .BYTE_CNT_WD(3)) bus ();

    axi_stream_insert_header #(.DATA_WD(32), .DATA_BYTE_WD(4), .BYTE_CNT_WD(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
        chk({tag, ".data"},  bus.data_out,       d);
        chk({tag, ".keep"},  32'(bus.keep_out),  32'(k));
        chk({tag, ".last"},  32'(bus.last_out),  32'(l));
    endtask

    task automatic hdr(input logic [31:0] d, input logic [3:0] k, input logic [2:0] n);
        bus.valid_insert    = 1'b1;
        bus.data_insert     = d;
        bus.keep_insert     = k;
        bus.byte_insert_cnt = n;
        tick();
        bus.valid_insert    = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
        bus.valid_insert = 1'b0; bus.data_insert = '0; bus.keep_insert = '0;
        bus.byte_insert_cnt = '0;
        bus.ready_out = 1'b1;

        // Reset values
        tick(); tick();
        chk("rst.valid", 32'(bus.valid_out), 32'd0);
        chk("rst.data",  bus.data_out,       32'd0);
        chk("rst.keep",  32'(bus.keep_out),  32'd0);
        chk("rst.last",  32'(bus.last_out),  32'd0);
        chk("rst.ready_in",     32'(bus.ready_in),     32'd0);
        chk("rst.ready_insert", 32'(bus.ready_insert), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle.ready_insert", 32'(bus.ready_insert), 32'd1);
        chk("idle.ready_in",     32'(bus.ready_in),     32'd0);

        // N=4: full-word header, always ends with a flush beat
        hdr(32'h12345678, 4'b1111, 3'd4);
        beat(32'hA5A5A5A5, 4'b1111, 1'b0);
        chk("n4.hdr_no_out", 32'(bus.valid_out), 32'd0);
        tick();
        chk_beat("n4.b0", 32'h12345678, 4'b1111, 1'b0);
        beat(32'hA5A5A5A5, 4'b1111, 1'b1);
        tick();
        bus.valid_in = 1'b0;
        chk_beat("n4.b1", 32'hA5A5A5A5, 4'b1111, 1'b0);
        chk("n4.flush_ready_in", 32'(bus.ready_in), 32'd0);
        tick();
        chk_beat("n4.b2", 32'hA5A5A5A5, 4'b1111, 1'b1);
        tick();
        chk("n4.idle_valid", 32'(bus.valid_out), 32'd0);

        // N=2, final beat fits
        hdr(32'h0000ABCD, 4'b0011, 3'd2);
        beat(32'h11223344, 4'b1111, 1'b0);
        tick();
        chk_beat("n2a.b0", 32'hABCD1122, 4'b1111, 1'b0);
        beat(32'h55667788, 4'b1100, 1'b1);
        tick();
        bus.valid_in = 1'b0;
        chk_beat("n2a.b1", 32'h33445566, 4'b1111, 1'b1);
        chk("n2a.idle_ready_in", 32'(bus.ready_in), 32'd0);

        // N=2, final beat spills into a flush beat
        chk("n2b.ready_insert", 32'(bus.ready_insert), 32'd1);
        hdr(32'h0000ABCD, 4'b0011, 3'd2);
        beat(32'h11223344, 4'b1111, 1'b0);
        tick();
        chk_beat("n2b.b0", 32'hABCD1122, 4'b1111, 1'b0);
        beat(32'h55667788, 4'b1110, 1'b1);
        tick();
        beat(32'h99999999, 4'b1111, 1'b0);
        chk_beat("n2b.b1", 32'h33445566, 4'b1111, 1'b0);
        chk("n2b.flush_ready_in", 32'(bus.ready_in), 32'd0);
        tick();
        bus.valid_in = 1'b0;
        chk_beat("n2b.b2", 32'h77000000, 4'b1000, 1'b1);

        // Backpressure mid-packet
        hdr(32'h0000ABCD, 4'b0011, 3'd2);
        beat(32'h11223344, 4'b1111, 1'b0);
        tick();
        chk_beat("bp.b0", 32'hABCD1122, 4'b1111, 1'b0);
        bus.ready_out = 1'b0;
        beat(32'h55667788, 4'b1100, 1'b1);
        #1;
        chk("bp.ready_in_low", 32'(bus.ready_in), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_beat("bp.hold", 32'hABCD1122, 4'b1111, 1'b0);
            chk("bp.hold_ready_in", 32'(bus.ready_in), 32'd0);
        end
        bus.ready_out = 1'b1;
        #1;
        chk("bp.ready_in_back", 32'(bus.ready_in), 32'd1);
        tick();
        bus.valid_in = 1'b0;
        chk_beat("bp.b1", 32'hDEAD0000 ^ 32'hEDE95566 ^ 32'h33445566 ^ 32'hEDE95566 ^ 32'hDEAD0000,
                 4'b1111, 1'b1);
        tick();
        chk("bp.drained", 32'(bus.valid_out), 32'd0);

        // Data before header is stalled; then N=0 pass-through with byte zeroing
        beat(32'hDEADBEEF, 4'b1100, 1'b1);
        #1;
        chk("ord.ready_in0", 32'(bus.ready_in), 32'd0);
        tick();
        chk("ord.ready_in1", 32'(bus.ready_in), 32'd0);
        chk("ord.no_out",    32'(bus.valid_out), 32'd0);
        bus.valid_insert = 1'b1; bus.data_insert = '0; bus.keep_insert = '0;
        bus.byte_insert_cnt = 3'd0;
        #1;
        chk("ord.ready_insert", 32'(bus.ready_insert), 32'd1);
        chk("ord.ready_in2",    32'(bus.ready_in),     32'd0);
        tick();
        bus.valid_insert = 1'b0;
        chk("ord.ready_in3", 32'(bus.ready_in), 32'd1);
        chk("ord.hdr_no_out", 32'(bus.valid_out), 32'd0);
        tick();
        bus.valid_in = 1'b0;
        chk_beat("ord.b0", 32'hDEAD0000, 4'b1100, 1'b1);

        // Mid-packet reset drops the partial packet
        hdr(32'h0000ABCD, 4'b0011, 3'd2);
        beat(32'h11223344, 4'b1111, 1'b0);
        tick();
        bus.valid_in = 1'b0;
        chk_beat("mr.b0", 32'hABCD1122, 4'b1111, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mr.ready_in",     32'(bus.ready_in),     32'd0);
        chk("mr.ready_insert", 32'(bus.ready_insert), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("mr.valid", 32'(bus.valid_out), 32'd0);
        chk("mr.keep",  32'(bus.keep_out),  32'd0);
        #1;
        chk("mr.idle_ready_insert", 32'(bus.ready_insert), 32'd1);
        hdr(32'h000000EE, 4'b0001, 3'd1);
        beat(32'hCAFEF00D, 4'b1000, 1'b1);
        tick();
        bus.valid_in = 1'b0;
        chk_beat("mr.b1", 32'hEECA0000, 4'b1100, 1'b1);
        tick();
        chk("mr.drained", 32'(bus.valid_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
